// File: rtl/apb_pkg.sv
// Shared APB definitions: completer state encoding, PPROT bit positions and
// a helper that derives the strobe width from the data width.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int PPROT_PRIV  = 0;
  localparam int PPROT_NSEC  = 1;
  localparam int PPROT_INSTR = 2;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Setup-phase address decode: maps a byte address onto a word index and flags
// out-of-window, misaligned or (optionally) non-secure accesses.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter int                    IDX_W       = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    SECURE_ONLY = 0
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [2:0]            pprot,
  output logic [IDX_W-1:0]      idx,
  output logic                  err
);

  localparam int LSB_W = $clog2(strb_width(DATA_WIDTH));

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word_off;
  logic                  unused_prot;

  assign unused_prot = pprot[PPROT_PRIV] ^ pprot[PPROT_INSTR];

  // Alignment is tested by shifting back rather than slicing low bits, so the
  // 8-bit configuration (no low bits at all) needs no special case.
  always_comb begin
    off      = paddr - BASE_ADDR;
    word_off = off >> LSB_W;
    idx      = word_off[IDX_W-1:0];
    err      = (paddr < BASE_ADDR)
            || (word_off >= ADDR_WIDTH'(MEM_DEPTH))
            || ((word_off << LSB_W) != off)
            || ((SECURE_ONLY != 0) && pprot[PPROT_NSEC]);
  end

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 completer in front of a word-addressed RAM with programmable wait
// states, byte strobes and PSLVERR on decode or protection failures.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter int                    SECURE_ONLY = 0
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic                    pready,
  output logic                    pslverr,
  output logic [DATA_WIDTH-1:0]   prdata
);

  localparam int STRB_W = strb_width(DATA_WIDTH);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic             write_q, write_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] dec_idx;
  logic             dec_err;
  logic             complete;
  logic             mem_we;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  apb_addr_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .MEM_DEPTH   (MEM_DEPTH),
    .IDX_W       (IDX_W),
    .BASE_ADDR   (BASE_ADDR),
    .SECURE_ONLY (SECURE_ONLY)
  ) u_decode (
    .paddr (paddr),
    .pprot (pprot),
    .idx   (dec_idx),
    .err   (dec_err)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    err_d    = err_q;
    write_d  = write_q;
    idx_d    = idx_q;
    complete = 1'b0;
    if (state_q == IDLE) begin
      if (psel && !penable) begin
        state_d = ACCESS;
        wait_d  = 4'(WAIT_STATES);
        err_d   = dec_err;
        write_d = pwrite;
        idx_d   = dec_idx;
      end
    end else if (!psel) begin
      state_d = IDLE;
    end else if (penable) begin
      if (wait_q != 4'd0) begin
        wait_d = wait_q - 4'd1;
      end else begin
        complete = 1'b1;
        state_d  = IDLE;
      end
    end
  end

  assign pready  = complete && !prst;
  assign pslverr = pready && err_q;
  assign prdata  = (pready && !write_q && !err_q) ? mem[idx_q] : '0;
  assign mem_we  = pready && write_q && !err_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      write_q <= write_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto plain memory macros.
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (pstrb[i]) mem[idx_q][8*i +: 8] <= pwdata[8*i +: 8];
      end
    end
  end

endmodule
